// File: rtl/fe_branch_predictor_if.sv
// fe_branch_predictor_if: lookup/update bundle between the fetch/AGEX side and
// the gshare branch predictor. master = FE/AGEX side, slave = predictor.
// Signals: ready, lk_* (same-cycle next-PC lookup), up_* (resolved-branch update).
interface fe_branch_predictor_if #(
  parameter int DBITS          = 32,
  parameter int PT_INDEX_BITS  = 8,
  parameter int BTB_INDEX_BITS = 4
);
  logic                      ready;
  // lookup
  logic [DBITS-1:0]          lk_pc;
  logic                      lk_btb_hit;
  logic                      lk_taken;
  logic [DBITS-1:0]          lk_next_pc;
  logic [PT_INDEX_BITS-1:0]  lk_pt_index;
  logic [BTB_INDEX_BITS-1:0] lk_btb_index;
  // update
  logic                      up_valid;
  logic                      up_is_cond;
  logic [DBITS-1:0]          up_pc;
  logic                      up_taken;
  logic [DBITS-1:0]          up_target;
  logic [PT_INDEX_BITS-1:0]  up_pt_index;
  logic [BTB_INDEX_BITS-1:0] up_btb_index;
  logic                      up_mispredict;

  modport master (
    input  ready, lk_btb_hit, lk_taken, lk_next_pc, lk_pt_index, lk_btb_index,
    output lk_pc,
    output up_valid, up_is_cond, up_pc, up_taken, up_target,
    output up_pt_index, up_btb_index, up_mispredict
  );

  modport slave (
    output ready, lk_btb_hit, lk_taken, lk_next_pc, lk_pt_index, lk_btb_index,
    input  lk_pc,
    input  up_valid, up_is_cond, up_pc, up_taken, up_target,
    input  up_pt_index, up_btb_index, up_mispredict
  );
endinterface

// File: rtl/fe_branch_predictor.sv
// fe_branch_predictor: gshare direction predictor (2-bit counter PT indexed by
// PC^BHR) plus direct-mapped BTB. Lookup is combinational (0 cycles); updates
// land on the clock edge and are visible the next cycle. No backpressure.
// Ports: clk, reset (async, active-high), bp (slave modport: ready, lk_*, up_*).
// Optional: define BP_STATS_EN to add stat_branches / stat_mispredicts counters.
module fe_branch_predictor #(
  parameter int DBITS          = 32,
  parameter int BHR_BITS       = 8,
  parameter int PT_INDEX_BITS  = 8,
  parameter int BTB_INDEX_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  fe_branch_predictor_if.slave         bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]                  stat_branches,
  output logic [31:0]                  stat_mispredicts
`endif
);

  localparam int PT_ENTRIES  = 1 << PT_INDEX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS    = DBITS - BTB_INDEX_BITS - 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PT_INDEX_BITS-1:0]  r_sweep;
  logic [BHR_BITS-1:0]       r_bhr;
  logic [1:0]                r_pt      [PT_ENTRIES];
  logic [BTB_ENTRIES-1:0]    r_btb_vld;
  logic [TAG_BITS-1:0]       r_btb_tag [BTB_ENTRIES];
  logic [DBITS-1:0]          r_btb_tgt [BTB_ENTRIES];

  logic                      w_run;
  logic                      w_sweep_en;
  logic                      w_upd;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_sweep == {PT_INDEX_BITS{1'b1}}) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_run      = 1'b0;
    w_sweep_en = 1'b0;
    case (r_state)
      ST_INIT: w_sweep_en = 1'b1;
      ST_RUN:  w_run      = 1'b1;
      default: w_sweep_en = 1'b1;
    endcase
  end

  assign bp.ready = w_run;
  assign w_upd    = w_run & bp.up_valid;

  // PT initialization sweep pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_sweep <= '0;
    else if (w_sweep_en) r_sweep <= r_sweep + 1'b1;
  end

  // ---------------- Lookup ----------------
  logic [PT_INDEX_BITS-1:0]  w_bhr_ext;
  logic [PT_INDEX_BITS-1:0]  w_lk_pt_idx;
  logic [BTB_INDEX_BITS-1:0] w_lk_btb_idx;
  logic [TAG_BITS-1:0]       w_lk_tag;
  logic                      w_lk_hit;
  logic                      w_lk_taken;

  // History is narrower than (or equal to) the PT index; upper bits stay zero.
  always_comb begin
    w_bhr_ext                 = '0;
    w_bhr_ext[BHR_BITS-1:0]   = r_bhr;
  end

  assign w_lk_pt_idx  = bp.lk_pc[PT_INDEX_BITS+1:2] ^ w_bhr_ext;
  assign w_lk_btb_idx = bp.lk_pc[BTB_INDEX_BITS+1:2];
  assign w_lk_tag     = bp.lk_pc[DBITS-1:BTB_INDEX_BITS+2];
  assign w_lk_hit     = w_run & r_btb_vld[w_lk_btb_idx] &
                        (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
  // Direction only matters when we know where to go.
  assign w_lk_taken   = w_lk_hit & r_pt[w_lk_pt_idx][1];

  assign bp.lk_pt_index  = w_lk_pt_idx;
  assign bp.lk_btb_index = w_lk_btb_idx;
  assign bp.lk_btb_hit   = w_lk_hit;
  assign bp.lk_taken     = w_lk_taken;
  assign bp.lk_next_pc   = w_lk_taken ? r_btb_tgt[w_lk_btb_idx]
                                      : bp.lk_pc + DBITS'(4);

  // ---------------- Pattern table write port ----------------
  // Single write port shared by the init sweep and resolved updates; the two
  // never overlap because updates are only accepted in RUN.
  logic                     w_pt_we;
  logic [PT_INDEX_BITS-1:0] w_pt_wa;
  logic [1:0]               w_pt_wd;
  logic [1:0]               w_pt_old;

  assign w_pt_old = r_pt[bp.up_pt_index];

  always_comb begin
    w_pt_we = 1'b0;
    w_pt_wa = '0;
    w_pt_wd = 2'b00;
    if (w_sweep_en) begin
      w_pt_we = 1'b1;
      w_pt_wa = r_sweep;
      w_pt_wd = 2'b01;
    end else if (w_upd) begin
      w_pt_we = 1'b1;
      w_pt_wa = bp.up_pt_index;
      if (!bp.up_is_cond)  w_pt_wd = 2'b11;
      else if (bp.up_taken) w_pt_wd = (w_pt_old == 2'b11) ? 2'b11 : w_pt_old + 2'd1;
      else                  w_pt_wd = (w_pt_old == 2'b00) ? 2'b00 : w_pt_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pt_we) r_pt[w_pt_wa] <= w_pt_wd;
  end

  // ---------------- Global history ----------------
  logic [BHR_BITS-1:0] w_bhr_nxt;

  always_comb begin
    w_bhr_nxt    = r_bhr << 1;
    w_bhr_nxt[0] = bp.up_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_bhr <= '0;
    else if (w_upd) r_bhr <= w_bhr_nxt;
  end

  // ---------------- BTB ----------------
  // Only taken outcomes allocate; a not-taken branch leaves its entry alone.
  logic w_btb_we;
  assign w_btb_we = w_upd & bp.up_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_btb_vld <= '0;
    else if (w_btb_we) r_btb_vld[bp.up_btb_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[bp.up_btb_index] <= bp.up_pc[DBITS-1:BTB_INDEX_BITS+2];
      r_btb_tgt[bp.up_btb_index] <= bp.up_target;
    end
  end

`ifdef BP_STATS_EN
  // ---------------- Statistics ----------------
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_upd) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (bp.up_mispredict) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;

  logic w_unused;
  assign w_unused = ^{bp.up_pc[BTB_INDEX_BITS+1:0]};
`else
  logic w_unused;
  assign w_unused = ^{bp.up_pc[BTB_INDEX_BITS+1:0], bp.up_mispredict};
`endif

endmodule

// File: tb/tb_fe_branch_predictor.sv
// tb_fe_branch_predictor: scoreboard bench for fe_branch_predictor. A small
// reference model predicts each lookup; predictions are queued when a lookup is
// driven and popped/compared when the combinational outputs are sampled.
module tb_fe_branch_predictor;

  localparam int DBITS = 32;
  localparam int BHRB  = 8;
  localparam int PTB   = 8;
  localparam int BTBB  = 4;

  logic clk;
  logic reset;

  fe_branch_predictor_if #(.DBITS(DBITS), .PT_INDEX_BITS(PTB), .BTB_INDEX_BITS(BTBB)) bp_if ();

`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  fe_branch_predictor #(
    .DBITS(DBITS), .BHR_BITS(BHRB), .PT_INDEX_BITS(PTB), .BTB_INDEX_BITS(BTBB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ready;
    logic        hit;
    logic        taken;
    logic [31:0] next_pc;
    logic [7:0]  pt_idx;
    logic [3:0]  btb_idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [1:0]  m_pt  [256];
  logic        m_vld [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [7:0]  m_bhr;
  bit          m_run;
  int unsigned m_br;
  int unsigned m_mp;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    e.ready   = m_run;
    e.pt_idx  = pc[9:2] ^ m_bhr;
    e.btb_idx = pc[5:2];
    e.hit     = m_run && m_vld[e.btb_idx] && (m_tag[e.btb_idx] == pc[31:6]);
    e.taken   = e.hit && m_pt[e.pt_idx][1];
    e.next_pc = e.taken ? m_tgt[e.btb_idx] : pc + 32'd4;
    return e;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_bhr = '0;
    m_br  = 0;
    m_mp  = 0;
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  task automatic model_init_done();
    m_run = 1;
    for (int i = 0; i < 256; i++) m_pt[i] = 2'b01;
  endtask

  // All tasks start and end at negedge+1; inputs change away from posedge.
  task automatic lookup(input logic [31:0] pc);
    exp_t e;
    bp_if.lk_pc = pc;
    sb_q.push_back(predict(pc));
    #1;
    e = sb_q.pop_front();
    chk("ready",        {31'd0, bp_if.ready},      {31'd0, e.ready});
    chk("lk_btb_hit",   {31'd0, bp_if.lk_btb_hit}, {31'd0, e.hit});
    chk("lk_taken",     {31'd0, bp_if.lk_taken},   {31'd0, e.taken});
    chk("lk_next_pc",   bp_if.lk_next_pc,          e.next_pc);
    chk("lk_pt_index",  {24'd0, bp_if.lk_pt_index},  {24'd0, e.pt_idx});
    chk("lk_btb_index", {28'd0, bp_if.lk_btb_index}, {28'd0, e.btb_idx});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic update(input bit cond, input logic [31:0] pc, input bit taken,
                        input logic [31:0] tgt, input logic [7:0] pt_idx, input bit misp);
    logic [3:0] bi;
    bi = pc[5:2];
    bp_if.up_valid      = 1'b1;
    bp_if.up_is_cond    = cond;
    bp_if.up_pc         = pc;
    bp_if.up_taken      = taken;
    bp_if.up_target     = tgt;
    bp_if.up_pt_index   = pt_idx;
    bp_if.up_btb_index  = bi;
    bp_if.up_mispredict = misp;
    // A lookup in the same cycle as the update must see pre-update state.
    lookup(bp_if.lk_pc);
    @(posedge clk);
    if (m_run) begin
      m_bhr = {m_bhr[6:0], taken};
      if (!cond)           m_pt[pt_idx] = 2'd3;
      else if (taken)      m_pt[pt_idx] = (m_pt[pt_idx] == 2'd3) ? 2'd3 : m_pt[pt_idx] + 2'd1;
      else                 m_pt[pt_idx] = (m_pt[pt_idx] == 2'd0) ? 2'd0 : m_pt[pt_idx] - 2'd1;
      if (taken) begin
        m_vld[bi] = 1'b1;
        m_tag[bi] = pc[31:6];
        m_tgt[bi] = tgt;
      end
      m_br++;
      if (misp) m_mp++;
    end
    @(negedge clk);
    #1;
    bp_if.up_valid = 1'b0;
  endtask

  // Eight not-taken updates on an unrelated counter bring history back to 0.
  task automatic clear_bhr();
    repeat (8) update(1'b1, 32'h200, 1'b0, 32'h0, 8'h80, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    bit          tk;
    bit          cd;
    exp_t        e;

    reset               = 1'b1;
    bp_if.lk_pc         = 32'h100;
    bp_if.up_valid      = 1'b0;
    bp_if.up_is_cond    = 1'b0;
    bp_if.up_pc         = '0;
    bp_if.up_taken      = 1'b0;
    bp_if.up_target     = '0;
    bp_if.up_pt_index   = '0;
    bp_if.up_btb_index  = '0;
    bp_if.up_mispredict = 1'b0;
    model_reset();
    idle(2);
    lookup(32'h100);
    reset = 1'b0;

    // INIT: 256 cycles with ready low; one update here must be ignored.
    for (int i = 0; i < 256; i++) begin
      if (i == 100) update(1'b1, 32'h100, 1'b1, 32'h80, 8'h40, 1'b1);
      else begin
        lookup(32'h100);
        idle(1);
      end
    end
    model_init_done();
    chk("ready_after_init", {31'd0, bp_if.ready}, 32'd1);
    lookup(32'h100);

    // First taken update allocates BTB, counter 01->10.
    update(1'b1, 32'h100, 1'b1, 32'h040, 8'h40, 1'b0);
    clear_bhr();
    lookup(32'h100);
    chk("taken_after_alloc", {31'd0, bp_if.lk_taken}, 32'd1);
    chk("next_after_alloc",  bp_if.lk_next_pc, 32'h040);

    // Saturate down.
    repeat (5) update(1'b1, 32'h100, 1'b0, 32'h0, 8'h40, 1'b1);
    lookup(32'h100);
    chk("taken_floor", {31'd0, bp_if.lk_taken}, 32'd0);
    chk("next_floor",  bp_if.lk_next_pc, 32'h104);

    // Saturate up: four taken (cap at 3), one not-taken leaves 2 -> taken.
    repeat (4) update(1'b1, 32'h100, 1'b1, 32'h040, 8'h40, 1'b0);
    clear_bhr();
    update(1'b1, 32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
    clear_bhr();
    lookup(32'h100);
    chk("taken_cap", {31'd0, bp_if.lk_taken}, 32'd1);

    // JAL forces counter to 3.
    repeat (3) update(1'b1, 32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
    update(1'b0, 32'h100, 1'b1, 32'h040, 8'h40, 1'b0);
    update(1'b1, 32'h100, 1'b0, 32'h0, 8'h40, 1'b0);
    clear_bhr();
    lookup(32'h100);
    chk("taken_jal", {31'd0, bp_if.lk_taken}, 32'd1);

    // History: taken, not-taken, taken -> 0b101.
    update(1'b1, 32'h204, 1'b1, 32'h060, 8'h81, 1'b0);
    update(1'b1, 32'h204, 1'b0, 32'h0,   8'h81, 1'b0);
    update(1'b1, 32'h204, 1'b1, 32'h060, 8'h81, 1'b0);
    lookup(32'h100);
    chk("pt_index_bhr", {24'd0, bp_if.lk_pt_index}, 32'h45);

    // BTB alias: 0x140 evicts 0x100 in entry 0.
    update(1'b1, 32'h100, 1'b1, 32'h040, 8'h40, 1'b0);
    update(1'b1, 32'h140, 1'b1, 32'h080, 8'h50, 1'b0);
    lookup(32'h100);
    chk("alias_hit", {31'd0, bp_if.lk_btb_hit}, 32'd0);
    lookup(32'h140);

    // Mixed random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      pc = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        tk = ($urandom_range(0, 2) != 0);
        cd = ($urandom_range(0, 3) != 0);
        e  = predict(pc);
        bp_if.lk_pc = 32'($urandom_range(0, 63)) << 2;
        update(cd, pc, tk, 32'($urandom_range(0, 255)) << 2, e.pt_idx, tk != e.taken);
      end else begin
        lookup(pc);
        idle(1);
      end
    end

    // Asynchronous reset mid-RUN.
    reset = 1'b1;
    #1;
    model_reset();
    chk("ready_in_reset", {31'd0, bp_if.ready}, 32'd0);
    lookup(32'h140);
`ifdef BP_STATS_EN
    chk("stat_br_reset", stat_branches, 32'd0);
    chk("stat_mp_reset", stat_mispredicts, 32'd0);
`endif
    idle(2);
    reset = 1'b0;
    idle(256);
    model_init_done();
    chk("ready_reinit", {31'd0, bp_if.ready}, 32'd1);
    lookup(32'h140);

`ifdef BP_STATS_EN
    update(1'b1, 32'h300, 1'b1, 32'h10, 8'h00, 1'b0);
    update(1'b1, 32'h300, 1'b0, 32'h0,  8'h00, 1'b1);
    update(1'b0, 32'h304, 1'b1, 32'h20, 8'h01, 1'b0);
    chk("stat_branches",    stat_branches,    m_br);
    chk("stat_mispredicts", stat_mispredicts, m_mp);
    chk("stat_br_three",    stat_branches,    32'd3);
    chk("stat_mp_one",      stat_mispredicts, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
